// File: rtl/exc_seq_pkg.sv
// Shared definitions for the interrupt entry/exit sequencer: state encodings,
// PC-select codes, the default ISR vector and the state-to-control decode.
package exc_seq_pkg;

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_WAIT = 3'd1,
    ST_SAVE = 3'd2,
    ST_VEC  = 3'd3,
    ST_RET  = 3'd4
  } exc_state_e;

  localparam logic [1:0]  PCSEL_NORM    = 2'b00;
  localparam logic [1:0]  PCSEL_ISR     = 2'b01;
  localparam logic [1:0]  PCSEL_EPC     = 2'b10;
  localparam logic [31:0] ISR_ADDR_DFLT = 32'h0000_4180;

  typedef struct packed {
    logic       stall;
    logic       epc_ld;
    logic       exl_set;
    logic       exl_clr;
    logic       pc_wr;
    logic [1:0] pc_sel;
    logic       int_ack;
  } exc_ctl_t;

  // Moore decode of one state into the full set of sequencer controls.
  function automatic exc_ctl_t exc_decode(input exc_state_e st);
    exc_ctl_t ctl;
    ctl = exc_ctl_t'(8'h00);
    case (st)
      ST_RUN: ctl = exc_ctl_t'(8'h00);
      ST_WAIT: ctl.stall = 1'b1;
      ST_SAVE: begin
        ctl.stall   = 1'b1;
        ctl.epc_ld  = 1'b1;
        ctl.exl_set = 1'b1;
      end
      ST_VEC: begin
        ctl.stall   = 1'b1;
        ctl.pc_wr   = 1'b1;
        ctl.pc_sel  = PCSEL_ISR;
        ctl.int_ack = 1'b1;
      end
      ST_RET: begin
        ctl.stall   = 1'b1;
        ctl.pc_wr   = 1'b1;
        ctl.pc_sel  = PCSEL_EPC;
        ctl.exl_clr = 1'b1;
      end
      default: ctl = exc_ctl_t'(8'h00);
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/exc_stat_cnt.sv
// Parameterised saturating event counter; holds at all-ones once reached.
module exc_stat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count events, stopping at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/exc_seq.sv
// Interrupt entry/exit sequencer: drain, save EPC, set EXL, vector; eret returns.
// Optional statistics counter (IntCnt port) enabled by defining EXC_STAT_EN.
module exc_seq
  import exc_seq_pkg::*;
#(
  parameter logic [31:0] ISR_ADDR = ISR_ADDR_DFLT,
  parameter int          STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IntReq,
  input  logic              InstrDone,
  input  logic              IsEret,
  input  logic [31:2]       NextPC,
  input  logic [31:2]       EPC,
  output logic              Stall,
  output logic              EPCLd,
  output logic [31:2]       EPCVal,
  output logic              EXLSet,
  output logic              EXLClr,
  output logic              PCWr,
  output logic [1:0]        PCSel,
`ifdef EXC_STAT_EN
  output logic              IntAck,
  output logic [STAT_W-1:0] IntCnt
`else
  output logic              IntAck
`endif
);

  if (STAT_W < 1) begin : g_bad_stat_w
    $error("exc_seq: STAT_W must be at least 1");
  end

  exc_state_e  state_r, next_state_s;
  exc_ctl_t    ctl_r;
  logic        latch_s;
  logic [31:2] epc_val_r;

  // Next-state selection and the NextPC capture decision.
  always_comb begin
    next_state_s = state_r;
    latch_s      = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (InstrDone && IsEret) begin
          next_state_s = ST_RET;
        end else if (IntReq && InstrDone) begin
          next_state_s = ST_SAVE;
          latch_s      = 1'b1;
        end else if (IntReq) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      // Retire commits the interrupt even if IntReq fell this cycle.
      ST_WAIT: begin
        if (InstrDone) begin
          next_state_s = ST_SAVE;
          latch_s      = 1'b1;
        end else if (!IntReq) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_SAVE: next_state_s = ST_VEC;
      ST_VEC:  next_state_s = ST_RUN;
      ST_RET:  next_state_s = ST_RUN;
      default: next_state_s = ST_RUN;
    endcase
  end

  // State, resume address and controls; controls are pre-decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RUN;
      ctl_r     <= exc_ctl_t'(8'h00);
      epc_val_r <= 30'd0;
    end else begin
      state_r <= next_state_s;
      ctl_r   <= exc_decode(next_state_s);
      if (latch_s) begin
        epc_val_r <= NextPC;
      end else begin
        epc_val_r <= epc_val_r;
      end
    end
  end

  assign Stall  = ctl_r.stall;
  assign EPCLd  = ctl_r.epc_ld;
  assign EXLSet = ctl_r.exl_set;
  assign EXLClr = ctl_r.exl_clr;
  assign PCWr   = ctl_r.pc_wr;
  assign PCSel  = ctl_r.pc_sel;
  assign IntAck = ctl_r.int_ack;
  assign EPCVal = epc_val_r;

`ifdef EXC_STAT_EN
  exc_stat_cnt #(
    .W (STAT_W)
  ) u_stat_cnt (
    .clk (clk),
    .rst (rst),
    .inc (state_r == ST_VEC),
    .cnt (IntCnt)
  );
`endif

endmodule

// File: tb/tb_exc_seq.sv
// Directed self-checking bench for exc_seq; counter checks run when EXC_STAT_EN is defined.
module tb_exc_seq;

  logic        clk;
  logic        rst;
  logic        IntReq;
  logic        InstrDone;
  logic        IsEret;
  logic [31:2] NextPC;
  logic [31:2] EPC;
  logic        Stall;
  logic        EPCLd;
  logic [31:2] EPCVal;
  logic        EXLSet;
  logic        EXLClr;
  logic        PCWr;
  logic [1:0]  PCSel;
  logic        IntAck;
`ifdef EXC_STAT_EN
  logic [1:0]  IntCnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  // Control word order: Stall EPCLd EXLSet EXLClr PCWr PCSel[1:0] IntAck.
  localparam logic [7:0] C_RUN  = 8'h00;
  localparam logic [7:0] C_WAIT = 8'h80;
  localparam logic [7:0] C_SAVE = 8'hE0;
  localparam logic [7:0] C_VEC  = 8'h8B;
  localparam logic [7:0] C_RET  = 8'h9C;

  logic [7:0] ctl;
  assign ctl = {Stall, EPCLd, EXLSet, EXLClr, PCWr, PCSel, IntAck};

  exc_seq #(
    .ISR_ADDR (32'h0000_4180),
    .STAT_W   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .IntReq    (IntReq),
    .InstrDone (InstrDone),
    .IsEret    (IsEret),
    .NextPC    (NextPC),
    .EPC       (EPC),
    .Stall     (Stall),
    .EPCLd     (EPCLd),
    .EPCVal    (EPCVal),
    .EXLSet    (EXLSet),
    .EXLClr    (EXLClr),
    .PCWr      (PCWr),
    .PCSel     (PCSel),
`ifdef EXC_STAT_EN
    .IntAck    (IntAck),
    .IntCnt    (IntCnt)
`else
    .IntAck    (IntAck)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (EPCLd || EXLSet || IntAck) pulse_cnt = pulse_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic done, input logic eret, input logic [31:2] npc);
    IntReq    = ir;
    InstrDone = done;
    IsEret    = eret;
    NextPC    = npc;
  endtask

  int lat;
  int waits;
  int p0;

  initial begin
    rst = 1'b1;
    EPC = 30'h3FFF_FFFF;
    drive(1'b1, 1'b1, 1'b1, 30'h3FFF_FFFF);
    step();
    step();
    chk("rst_ctl", {24'd0, ctl}, {24'd0, C_RUN});
    chk("rst_epcval", {2'b00, EPCVal}, 32'd0);
`ifdef EXC_STAT_EN
    chk("rst_intcnt", {30'd0, IntCnt}, 32'd0);
`endif

    // Interrupt right after reset, first through WAIT.
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 30'h0);
    step();
    chk("post_rst_wait", {24'd0, ctl}, {24'd0, C_WAIT});
    drive(1'b1, 1'b1, 1'b0, 30'h0000_0123);
    step();
    chk("post_rst_save", {24'd0, ctl}, {24'd0, C_SAVE});
    chk("post_rst_epcval", {2'b00, EPCVal}, 32'h0000_0123);
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    step();
    chk("post_rst_vec", {24'd0, ctl}, {24'd0, C_VEC});
    step();
    chk("post_rst_run", {24'd0, ctl}, {24'd0, C_RUN});

    // Direct take; inputs during SAVE are ignored and EPCVal holds.
    drive(1'b1, 1'b1, 1'b0, 30'h0000_0C05);
    step();
    chk("direct_save", {24'd0, ctl}, {24'd0, C_SAVE});
    chk("direct_epcval", {2'b00, EPCVal}, 32'h0000_0C05);
    drive(1'b1, 1'b1, 1'b0, 30'h3FFF_FFFF);
    step();
    chk("direct_vec", {24'd0, ctl}, {24'd0, C_VEC});
    chk("direct_epc_hold", {2'b00, EPCVal}, 32'h0000_0C05);
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    step();
    chk("direct_run", {24'd0, ctl}, {24'd0, C_RUN});

    // Four WAIT cycles before the retire: fetch at ISR on cycle 7.
    lat = 0;
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      drive((i < 5) ? 1'b1 : 1'b0, (i == 4) ? 1'b1 : 1'b0, 1'b0, 30'h0000_002A);
      step();
      lat++;
      if (ctl == C_WAIT) waits++;
      if (PCWr && (PCSel == 2'b01)) break;
    end
    chk("wait_cycles", waits, 32'd4);
    chk("int_latency", lat + 1, 32'd7);
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    step();
    chk("lat_run", {24'd0, ctl}, {24'd0, C_RUN});
    chk("lat_epcval", {2'b00, EPCVal}, 32'h0000_002A);

    // IntReq withdrawn in WAIT: back to RUN, no pulses, EPCVal untouched.
    p0 = pulse_cnt;
    drive(1'b1, 1'b0, 1'b0, 30'h0000_0155);
    step();
    chk("cancel_wait", {24'd0, ctl}, {24'd0, C_WAIT});
    drive(1'b0, 1'b0, 1'b0, 30'h0000_0155);
    step();
    chk("cancel_run", {24'd0, ctl}, {24'd0, C_RUN});
    step();
    chk("cancel_stay", {24'd0, ctl}, {24'd0, C_RUN});
    chk("cancel_no_pulse", pulse_cnt - p0, 32'd0);
    chk("cancel_epcval", {2'b00, EPCVal}, 32'h0000_002A);

    // Retire in WAIT commits the interrupt even as IntReq falls.
    drive(1'b1, 1'b0, 1'b0, 30'h0);
    step();
    drive(1'b0, 1'b1, 1'b0, 30'h0000_0ABC);
    step();
    chk("commit_save", {24'd0, ctl}, {24'd0, C_SAVE});
    chk("commit_epcval", {2'b00, EPCVal}, 32'h0000_0ABC);
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    step();
    chk("commit_vec", {24'd0, ctl}, {24'd0, C_VEC});
    step();

    // Stray eret in WAIT is a normal retire.
    drive(1'b1, 1'b0, 1'b0, 30'h0);
    step();
    drive(1'b1, 1'b1, 1'b1, 30'h0000_0DEF);
    step();
    chk("wait_eret_save", {24'd0, ctl}, {24'd0, C_SAVE});
    chk("wait_eret_epcval", {2'b00, EPCVal}, 32'h0000_0DEF);
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    step();
    step();
    chk("wait_eret_run", {24'd0, ctl}, {24'd0, C_RUN});

    // Eret beats a simultaneous IntReq; interrupt taken later from RUN.
    EPC = 30'h0000_0C05;
    drive(1'b1, 1'b1, 1'b1, 30'h0000_0111);
    step();
    chk("eret_ret", {24'd0, ctl}, {24'd0, C_RET});
    chk("eret_epc_hold", {2'b00, EPCVal}, 32'h0000_0DEF);
    drive(1'b1, 1'b0, 1'b0, 30'h0);
    step();
    chk("eret_run", {24'd0, ctl}, {24'd0, C_RUN});
    drive(1'b1, 1'b1, 1'b0, 30'h0000_0222);
    step();
    chk("eret_then_save", {24'd0, ctl}, {24'd0, C_SAVE});
    chk("eret_then_epcval", {2'b00, EPCVal}, 32'h0000_0222);
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    step();
    chk("eret_then_vec", {24'd0, ctl}, {24'd0, C_VEC});
    step();

    // Reset in the middle of a sequence.
    drive(1'b1, 1'b1, 1'b0, 30'h0000_0333);
    step();
    rst = 1'b1;
    step();
    chk("midseq_rst_ctl", {24'd0, ctl}, {24'd0, C_RUN});
    chk("midseq_rst_epcval", {2'b00, EPCVal}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    step();

`ifdef EXC_STAT_EN
    // Two-bit counter saturates at 3; reset clears it.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("cnt_zero", {30'd0, IntCnt}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, 30'(k));
      step();
      drive(1'b0, 1'b0, 1'b0, 30'h0);
      step();
      step();
      chk($sformatf("cnt_take%0d", k), {30'd0, IntCnt}, (k < 2) ? 32'(k + 1) : 32'd3);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("cnt_rst", {30'd0, IntCnt}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
